// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch responder with PC, byte prefetch buffer and req/ack memory reads
// Ports: clk/rst (sync, active-low); fetch pops the buffer head; pc_load/pc_in redirect fetch;
// instr/instr_valid/pc present the head byte and its address; mem_req/mem_addr/mem_ack/mem_data
// form the byte-read handshake to instruction memory.
module fetch_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [7:0]            instr,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    state_t state;
    logic [7:0] buf_data [DEPTH];
    logic [ADDR_WIDTH-1:0] buf_addr [DEPTH];
    logic [PW-1:0] rd, wr;
    logic [CW-1:0] count, count_nx;
    logic [ADDR_WIDTH-1:0] fa, nfa;
    logic ack, pop, push, space;
    assign ack = mem_req && mem_ack;
    assign instr_valid = count != '0;
    assign instr = buf_data[rd];
    assign pc = buf_addr[rd];
    // a jump kills both the pop and any data returning this cycle
    assign pop = fetch && instr_valid && !pc_load;
    assign push = ack && state == REQ && !pc_load;
    assign count_nx = pc_load ? '0 : count + CW'(push) - CW'(pop);
    assign space = count_nx < CW'(DEPTH);
    assign nfa = pc_load ? pc_in : fa;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_addr <= RESET_PC;
            fa <= RESET_PC;
            rd <= '0;
            wr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_addr[i] <= '0;
            end
        end else begin
            count <= count_nx;
            if (pc_load) begin
                rd <= '0;
                wr <= '0;
            end else begin
                if (push) begin
                    buf_data[wr] <= mem_data;
                    buf_addr[wr] <= mem_addr;
                    wr <= wr + 1'b1;
                end
                if (pop) rd <= rd + 1'b1;
            end
            case (state)
                IDLE: begin
                    fa <= nfa;
                    if (space) begin
                        state <= REQ;
                        mem_req <= 1'b1;
                        mem_addr <= nfa;
                    end
                end
                REQ: begin
                    if (pc_load) begin
                        fa <= pc_in;
                        // same-cycle ack: drop it and retarget; otherwise wait out the stale read
                        if (ack) mem_addr <= pc_in;
                        else state <= DISCARD;
                    end else if (ack) begin
                        fa <= fa + 1'b1;
                        if (space) mem_addr <= fa + 1'b1;
                        else begin
                            state <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    fa <= nfa;
                    if (ack) begin
                        if (space) begin
                            state <= REQ;
                            mem_addr <= nfa;
                        end else begin
                            state <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst, fetch, pc_load, mem_ack, mem_req, instr_valid;
    logic [15:0] pc_in, pc, mem_addr;
    logic [7:0] instr, mem_data;
    logic mem_ok, ovr_en;
    int n_chk = 0;
    int n_fail = 0;

    fetch_unit #(.ADDR_WIDTH(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .pc_load(pc_load), .pc_in(pc_in),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        case (a)
            16'h0000: return 8'hA0;
            16'h0001: return 8'hB1;
            16'h0002: return 8'hC2;
            16'h0003: return 8'hD3;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign mem_ack = mem_req && mem_ok;
    assign mem_data = ovr_en ? 8'h55 : mem_fn(mem_addr);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // fill A0,B1, pop A0, leave the read of 0x0002 stalled
    task automatic setup_stall();
        mem_ok = 1'b1;
        fetch = 1'b0;
        pc_load = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        fetch = 1'b1;
        mem_ok = 1'b0;
        tick();
        fetch = 1'b0;
    endtask

    initial begin
        rst = 1'b0; fetch = 1'b0; pc_load = 1'b0; pc_in = '0; mem_ok = 1'b1; ovr_en = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_addr", mem_addr, 0);
        // test 1: latency and fill
        rst = 1'b1;
        tick();
        chk("t1_e1_req", mem_req, 1);
        chk("t1_e1_valid", instr_valid, 0);
        tick();
        chk("t1_e2_valid", instr_valid, 1);
        chk("t1_e2_instr", instr, 8'hA0);
        chk("t1_e2_pc", pc, 0);
        chk("t1_e2_addr", mem_addr, 1);
        tick();
        chk("t1_e3_req", mem_req, 0);
        chk("t1_e3_instr", instr, 8'hA0);
        tick();
        chk("t1_full_req", mem_req, 0);
        // test 2: continuous fetch
        fetch = 1'b1;
        tick();
        chk("t2_instr1", instr, 8'hB1);
        chk("t2_pc1", pc, 1);
        tick();
        chk("t2_instr2", instr, 8'hC2);
        chk("t2_pc2", pc, 2);
        tick();
        chk("t2_instr3", instr, 8'hD3);
        chk("t2_pc3", pc, 3);
        chk("t2_valid3", instr_valid, 1);
        fetch = 1'b0;
        // test 3: three wait states on 0x0002
        setup_stall();
        chk("t3_instr", instr, 8'hB1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_req_hold", mem_req, 1);
            chk("t3_addr_hold", mem_addr, 16'h0002);
            chk("t3_head_hold", instr, 8'hB1);
        end
        mem_ok = 1'b1;
        tick();
        chk("t3_ack_req", mem_req, 0);
        fetch = 1'b1;
        tick();
        chk("t3_pop_instr", instr, 8'hC2);
        chk("t3_pop_pc", pc, 2);
        tick();
        chk("t3_nodup_instr", instr, 8'hD3);
        chk("t3_nodup_pc", pc, 3);
        fetch = 1'b0;
        // test 4: jump while 0x0002 outstanding, stale 0x55 arrives later
        setup_stall();
        pc_load = 1'b1;
        pc_in = 16'h1234;
        tick();
        pc_load = 1'b0;
        chk("t4_flush_valid", instr_valid, 0);
        chk("t4_hold_req", mem_req, 1);
        chk("t4_hold_addr", mem_addr, 16'h0002);
        tick();
        chk("t4_wait_addr", mem_addr, 16'h0002);
        chk("t4_wait_valid", instr_valid, 0);
        mem_ok = 1'b1;
        ovr_en = 1'b1;
        tick();
        ovr_en = 1'b0;
        chk("t4_drop_valid", instr_valid, 0);
        chk("t4_new_addr", mem_addr, 16'h1234);
        chk("t4_new_req", mem_req, 1);
        tick();
        chk("t4_instr", instr, 8'h6E);
        chk("t4_pc", pc, 16'h1234);
        tick();
        // test 5: wrap at 0xFFFF
        pc_load = 1'b1;
        pc_in = 16'hFFFF;
        tick();
        pc_load = 1'b0;
        chk("t5_valid", instr_valid, 0);
        chk("t5_addr_ffff", mem_addr, 16'hFFFF);
        tick();
        chk("t5_instr_ffff", instr, 8'hA5);
        chk("t5_pc_ffff", pc, 16'hFFFF);
        chk("t5_addr_0", mem_addr, 16'h0000);
        tick();
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        chk("t5_pc_0", pc, 16'h0000);
        chk("t5_instr_0", instr, 8'hA0);
        // test 6a: fetch with empty buffer is ignored
        mem_ok = 1'b0;
        pc_load = 1'b1;
        pc_in = 16'h0010;
        tick();
        pc_load = 1'b0;
        chk("t6a_disc_valid", instr_valid, 0);
        chk("t6a_disc_addr", mem_addr, 16'h0001);
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        chk("t6a_valid", instr_valid, 0);
        chk("t6a_req", mem_req, 1);
        chk("t6a_addr", mem_addr, 16'h0001);
        // test 6b: pc_load beats fetch
        mem_ok = 1'b1;
        tick();
        chk("t6b_addr10", mem_addr, 16'h0010);
        chk("t6b_valid0", instr_valid, 0);
        tick();
        chk("t6b_instr10", instr, 8'h4A);
        chk("t6b_pc10", pc, 16'h0010);
        pc_load = 1'b1;
        pc_in = 16'h0020;
        fetch = 1'b1;
        tick();
        pc_load = 1'b0;
        fetch = 1'b0;
        chk("t6b_load_valid", instr_valid, 0);
        chk("t6b_load_addr", mem_addr, 16'h0020);
        tick();
        chk("t6b_instr20", instr, 8'h7A);
        chk("t6b_pc20", pc, 16'h0020);
        chk("t6b_valid20", instr_valid, 1);
        tick();
        chk("t6b_head_kept", instr, 8'h7A);
        chk("t6b_full_req", mem_req, 0);
        // test 6c: reset during REQ
        fetch = 1'b1;
        tick();
        fetch = 1'b0;
        mem_ok = 1'b0;
        chk("t6c_pc21", pc, 16'h0021);
        chk("t6c_req", mem_req, 1);
        chk("t6c_addr", mem_addr, 16'h0022);
        rst = 1'b0;
        tick();
        chk("t6c_rst_req", mem_req, 0);
        chk("t6c_rst_valid", instr_valid, 0);
        chk("t6c_rst_pc", pc, 0);
        chk("t6c_rst_addr", mem_addr, 0);
        rst = 1'b1;
        mem_ok = 1'b1;
        tick();
        chk("t6c_restart_req", mem_req, 1);
        chk("t6c_restart_addr", mem_addr, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
